// File: rtl/idss_load_sequencer_if.sv
// Stream, shift-structure and window signals of the IDSS load sequencer.
//   in_valid/in_ready/row_x_in      : upstream column beat stream
//   row_x_out/le_select_out/shift_out: drive to the 4-unit shift structure
//   win_valid_out/win_ready_in       : window handshake with the PE array
// slave  = sequencer side, master = environment side.
interface idss_load_sequencer_if #(
    parameter int IO_DATA_WIDTH = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [IO_DATA_WIDTH-1:0] row_1_in;
    logic [IO_DATA_WIDTH-1:0] row_2_in;
    logic [IO_DATA_WIDTH-1:0] row_3_in;
    logic [IO_DATA_WIDTH-1:0] row_1_out;
    logic [IO_DATA_WIDTH-1:0] row_2_out;
    logic [IO_DATA_WIDTH-1:0] row_3_out;
    logic [2:0]               le_select_out;
    logic                     shift_out;
    logic                     win_valid_out;
    logic                     win_ready_in;

    modport slave (
        input  in_valid, row_1_in, row_2_in, row_3_in, win_ready_in,
        output in_ready, row_1_out, row_2_out, row_3_out,
               le_select_out, shift_out, win_valid_out
    );

    modport master (
        output in_valid, row_1_in, row_2_in, row_3_in, win_ready_in,
        input  in_ready, row_1_out, row_2_out, row_3_out,
               le_select_out, shift_out, win_valid_out
    );
endinterface

// File: rtl/idss_load_sequencer.sv
// Load sequencer for the 4-unit input-data shift structure.
// Accepts 3-row column beats, fills units 1..NB_UNITS with COLS_PER_UNIT
// columns each, then presents a window to the PE array; repeats for
// nb_tiles_in tiles per start.
// Ports:
//   clk, rst_in   : clock, synchronous active-high reset
//   start_in      : start pulse (IDLE only), nb_tiles_in latched with it
//   busy_out      : high outside IDLE
//   done_out      : 1-cycle pulse after the last window is consumed
//   bus           : stream / shift-structure / window signals (slave side)
module idss_load_sequencer #(
    parameter int IO_DATA_WIDTH  = 16,
    parameter int NB_UNITS       = 4,
    parameter int COLS_PER_UNIT  = 3,
    parameter int TILE_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [TILE_CNT_WIDTH-1:0] nb_tiles_in,
    output logic                      busy_out,
    output logic                      done_out,
    idss_load_sequencer_if.slave      bus
);
    localparam int CW = (COLS_PER_UNIT > 1) ? $clog2(COLS_PER_UNIT) : 1;
    localparam int UW = (NB_UNITS > 1) ? $clog2(NB_UNITS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, WAIT_WIN} state_t;

    state_t                    state_q;
    logic [CW-1:0]             col_q;
    logic [UW-1:0]             unit_q;
    logic [TILE_CNT_WIDTH-1:0] tile_cnt_q;
    logic [TILE_CNT_WIDTH-1:0] nb_tiles_q;
    logic [IO_DATA_WIDTH-1:0]  row_1_q, row_2_q, row_3_q;
    logic [2:0]                le_sel_q;
    logic                      shift_q;
    logic                      win_valid_q;
    logic                      done_q;

    logic [TILE_CNT_WIDTH-1:0] tile_cnt_d;
    logic                      col_wrap, unit_wrap;

    assign tile_cnt_d = tile_cnt_q + TILE_CNT_WIDTH'(1);
    assign col_wrap   = (col_q == CW'(COLS_PER_UNIT - 1));
    assign unit_wrap  = (unit_q == UW'(NB_UNITS - 1));

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= IDLE;
            col_q       <= '0;
            unit_q      <= '0;
            tile_cnt_q  <= '0;
            nb_tiles_q  <= '0;
            row_1_q     <= '0;
            row_2_q     <= '0;
            row_3_q     <= '0;
            le_sel_q    <= '0;
            shift_q     <= 1'b0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // strobes default low; rows hold their last captured beat
            le_sel_q <= '0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        nb_tiles_q <= nb_tiles_in;
                        tile_cnt_q <= '0;
                        if (nb_tiles_in == '0) done_q  <= 1'b1;
                        else                   state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid is a beat
                    if (bus.in_valid) begin
                        row_1_q  <= bus.row_1_in;
                        row_2_q  <= bus.row_2_in;
                        row_3_q  <= bus.row_3_in;
                        le_sel_q <= 3'(unit_q) + 3'd1;
                        shift_q  <= 1'b1;
                        if (col_wrap) begin
                            col_q <= '0;
                            if (unit_wrap) begin
                                unit_q  <= '0;
                                state_q <= SETTLE;
                            end else begin
                                unit_q <= unit_q + UW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                SETTLE: begin
                    // one cycle for the LE decode inside the shift structure
                    win_valid_q <= 1'b1;
                    state_q     <= WAIT_WIN;
                end
                WAIT_WIN: begin
                    if (bus.win_ready_in) begin
                        win_valid_q <= 1'b0;
                        tile_cnt_q  <= tile_cnt_d;
                        if (tile_cnt_d == nb_tiles_q) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state_q == LOAD);
    assign bus.row_1_out     = row_1_q;
    assign bus.row_2_out     = row_2_q;
    assign bus.row_3_out     = row_3_q;
    assign bus.le_select_out = le_sel_q;
    assign bus.shift_out     = shift_q;
    assign bus.win_valid_out = win_valid_q;
    assign busy_out          = (state_q != IDLE);
    assign done_out          = done_q;
endmodule

// File: tb/tb_idss_load_sequencer.sv
module tb_idss_load_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  nb;
    logic         busy, done;

    idss_load_sequencer_if #(.IO_DATA_WIDTH(W)) bif ();

    idss_load_sequencer #(
        .IO_DATA_WIDTH(W), .NB_UNITS(4), .COLS_PER_UNIT(3), .TILE_CNT_WIDTH(16)
    ) u_dut (
        .clk         (clk),
        .rst_in      (rst),
        .start_in    (start),
        .nb_tiles_in (nb),
        .busy_out    (busy),
        .done_out    (done),
        .bus         (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [15:0] nb;
        logic        iv;
        logic [15:0] r1, r2, r3;
        logic        wr;
        logic        e_rdy;
        logic [2:0]  e_le;
        logic        e_sh, e_wv, e_busy, e_done;
        logic [15:0] e_r1, e_r2, e_r3;
    } vec_t;

    vec_t vt[32];
    int   nv;
    int   total = 0;
    int   passed = 0;

    function automatic vec_t mk(int st_, int nb_, int iv_, int r1_, int r2_, int r3_, int wr_,
                                int rdy_, int le_, int sh_, int wv_, int bz_, int dn_,
                                int er1, int er2, int er3);
        vec_t v;
        v.st = 1'(st_); v.nb = 16'(nb_); v.iv = 1'(iv_);
        v.r1 = 16'(r1_); v.r2 = 16'(r2_); v.r3 = 16'(r3_); v.wr = 1'(wr_);
        v.e_rdy = 1'(rdy_); v.e_le = 3'(le_); v.e_sh = 1'(sh_); v.e_wv = 1'(wv_);
        v.e_busy = 1'(bz_); v.e_done = 1'(dn_);
        v.e_r1 = 16'(er1); v.e_r2 = 16'(er2); v.e_r3 = 16'(er3);
        return v;
    endfunction

    function automatic logic [63:0] obs();
        return {8'h0, bif.in_ready, bif.le_select_out, bif.shift_out, bif.win_valid_out,
                busy, done, bif.row_1_out, bif.row_2_out, bif.row_3_out};
    endfunction

    function automatic logic [63:0] pack_exp(vec_t v);
        return {8'h0, v.e_rdy, v.e_le, v.e_sh, v.e_wv, v.e_busy, v.e_done,
                v.e_r1, v.e_r2, v.e_r3};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic v, input int base);
        bif.in_valid = v;
        bif.row_1_in = 16'(base);
        bif.row_2_in = 16'(base + 100);
        bif.row_3_in = 16'(base + 200);
    endtask

    // 12 back-to-back beats from LOAD; optionally pokes start_in mid-load
    task automatic feed12(input int base, input bit poke_start);
        for (int k = 0; k < 12; k++) begin
            drive_beat(1'b1, base + k);
            if (poke_start && k == 4) begin
                start = 1'b1;
                nb    = 16'd1;
            end
            cyc();
            start = 1'b0;
            chk($sformatf("feed%0d_b%0d", base, k),
                {24'h0, bif.le_select_out, bif.shift_out, bif.row_1_out, bif.row_2_out, bif.row_3_out},
                {24'h0, 3'((k / 3) + 1), 1'b1, 16'(base + k), 16'(base + k + 100), 16'(base + k + 200)});
        end
        bif.in_valid = 1'b0;
    endtask

    initial begin
        int b;
        int shifts, wins, dones, done_cyc;
        logic busy42, busy43;

        rst = 1'b1; start = 1'b0; nb = '0;
        drive_beat(1'b1, 55);
        bif.win_ready_in = 1'b1;
        cyc(); cyc();
        chk("reset_state", obs(), 64'h0);
        rst = 1'b0;
        drive_beat(1'b0, 0);
        bif.win_ready_in = 1'b0;

        // ---------- table: T1 (nb=1), T5 (nb=0), ignored inputs in IDLE
        nv = 0;
        vt[nv++] = mk(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0,  0, 0, 0);
        for (int k = 1; k <= 12; k++)
            vt[nv++] = mk(0, 0, 1, k, k + 100, k + 200, 0,
                          (k < 12) ? 1 : 0, (k - 1) / 3 + 1, 1, 0, 1, 0, k, k + 100, k + 200);
        vt[nv++] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0,  12, 112, 212);
        vt[nv++] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0,  12, 112, 212);
        vt[nv++] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0,  12, 112, 212);
        vt[nv++] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1,  12, 112, 212);
        vt[nv++] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  12, 112, 212);
        vt[nv++] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1,  12, 112, 212);
        vt[nv++] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  12, 112, 212);
        vt[nv++] = mk(0, 0, 1, 7, 7, 7, 1,  0, 0, 0, 0, 0, 0,  12, 112, 212);

        for (int i = 0; i < nv; i++) begin
            start = vt[i].st; nb = vt[i].nb; bif.in_valid = vt[i].iv;
            bif.row_1_in = vt[i].r1; bif.row_2_in = vt[i].r2; bif.row_3_in = vt[i].r3;
            bif.win_ready_in = vt[i].wr;
            cyc();
            chk($sformatf("vec%0d", i), obs(), pack_exp(vt[i]));
        end
        start = 1'b0; bif.in_valid = 1'b0; bif.win_ready_in = 1'b0;

        // ---------- T2: in_valid toggling
        start = 1'b1; nb = 16'd1; cyc(); start = 1'b0;
        b = 0;
        for (int i = 0; i < 24; i++) begin
            drive_beat((i % 2) == 0, 1000 + i);
            cyc();
            if ((i % 2) == 0) begin
                chk($sformatf("t2_beat%0d", b), {56'h0, bif.le_select_out, bif.shift_out, bif.row_1_out},
                    {56'h0, 3'((b / 3) + 1), 1'b1, 16'(1000 + i)} );
                b++;
            end else begin
                chk($sformatf("t2_idle%0d", i), {60'h0, bif.le_select_out, bif.shift_out},
                    64'h0);
            end
            if (i == 22) chk("t2_settle", {62'h0, bif.win_valid_out, bif.in_ready}, 64'h0);
        end
        chk("t2_winvalid", {62'h0, bif.win_valid_out, bif.in_ready}, 64'h2);
        bif.win_ready_in = 1'b1; cyc(); bif.win_ready_in = 1'b0;
        chk("t2_done", {62'h0, done, bif.win_valid_out}, 64'h2);
        cyc();

        // ---------- T3: window stall, nb=2, start poked mid-load
        start = 1'b1; nb = 16'd2; cyc(); start = 1'b0;
        feed12(300, 1'b1);
        cyc();
        chk("t3_wv", {63'h0, bif.win_valid_out}, 64'h1);
        for (int i = 0; i < 5; i++) begin
            drive_beat(1'b1, 900);
            cyc();
            chk($sformatf("t3_stall%0d", i),
                {58'h0, bif.win_valid_out, bif.in_ready, bif.le_select_out, bif.shift_out},
                {58'h0, 1'b1, 1'b0, 3'd0, 1'b0});
        end
        bif.in_valid = 1'b0; bif.win_ready_in = 1'b1; cyc(); bif.win_ready_in = 1'b0;
        chk("t3_release", {60'h0, bif.win_valid_out, bif.in_ready, busy, done}, 64'h6);
        feed12(400, 1'b0);
        cyc();
        bif.win_ready_in = 1'b1; cyc(); bif.win_ready_in = 1'b0;
        chk("t3_done", {62'h0, done, busy}, 64'h2);
        cyc();

        // ---------- T4: nb=3, win_ready tied high
        shifts = 0; wins = 0; dones = 0; done_cyc = -1; busy42 = 1'b0; busy43 = 1'b1;
        bif.win_ready_in = 1'b1;
        start = 1'b1; nb = 16'd3;
        drive_beat(1'b1, 2000);
        cyc(); start = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            if (bif.shift_out) shifts++;
            if (bif.win_valid_out) wins++;
            if (done) begin dones++; if (done_cyc < 0) done_cyc = n; end
            if (n == 42) busy42 = busy;
            if (n == 43) busy43 = busy;
            if (n < 50) begin drive_beat(1'b1, 2000 + n); cyc(); end
        end
        bif.in_valid = 1'b0; bif.win_ready_in = 1'b0;
        chk("t4_shifts", 64'(shifts), 64'd36);
        chk("t4_windows", 64'(wins), 64'd3);
        chk("t4_dones", 64'(dones), 64'd1);
        chk("t4_done_cycle", 64'(done_cyc), 64'd43);
        chk("t4_busy", {62'h0, busy42, busy43}, 64'h2);

        // ---------- T6: reset at beat 7, restart
        start = 1'b1; nb = 16'd1; cyc(); start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drive_beat(1'b1, 600 + k);
            cyc();
        end
        chk("t6_pre", {61'h0, bif.le_select_out}, 64'd3);
        rst = 1'b1; start = 1'b1; bif.win_ready_in = 1'b1;
        cyc();
        chk("t6_reset", obs(), 64'h0);
        rst = 1'b0; start = 1'b0; bif.in_valid = 1'b0; bif.win_ready_in = 1'b0;
        cyc();
        chk("t6_idle", obs(), 64'h0);
        start = 1'b1; nb = 16'd1; cyc(); start = 1'b0;
        chk("t6_load", {62'h0, bif.in_ready, busy}, 64'h3);
        feed12(500, 1'b0);
        cyc();
        chk("t6_wv", {63'h0, bif.win_valid_out}, 64'h1);
        bif.win_ready_in = 1'b1; cyc(); bif.win_ready_in = 1'b0;
        chk("t6_done", {62'h0, done, busy}, 64'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
